// File: rtl/sc_psrandom_arbiter.sv
// sc_psrandom_arbiter: round-robin arbiter that hands each winner a word from an 8-step LFSR run
// Ports:
//   SC_PSRANDOM_ARBITER_CLOCK_50    clock, all logic on the rising edge
//   SC_PSRANDOM_ARBITER_RESET_InLow synchronous active-low reset
//   SC_PSRANDOM_ARBITER_req_InBUS   level requests, one bit per requester
//   SC_PSRANDOM_ARBITER_seed_InBUS  seed value, taken while SC_PSRANDOM_ARBITER_seedLoad_In pulses in IDLE
//   SC_PSRANDOM_ARBITER_gnt_OutBUS  one-hot grant, DELIVER cycle only
//   SC_PSRANDOM_ARBITER_data_OutBUS live LFSR contents
//   SC_PSRANDOM_ARBITER_valid_Out   data is a delivered word, DELIVER cycle only
//   SC_PSRANDOM_ARBITER_busy_Out    high while SHIFT or DELIVER
module sc_psrandom_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 8
) (
    input  logic                 SC_PSRANDOM_ARBITER_CLOCK_50,
    input  logic                 SC_PSRANDOM_ARBITER_RESET_InLow,
    input  logic [NREQ-1:0]      SC_PSRANDOM_ARBITER_req_InBUS,
    input  logic [DATAWIDTH-1:0] SC_PSRANDOM_ARBITER_seed_InBUS,
    input  logic                 SC_PSRANDOM_ARBITER_seedLoad_In,
    output logic [NREQ-1:0]      SC_PSRANDOM_ARBITER_gnt_OutBUS,
    output logic [DATAWIDTH-1:0] SC_PSRANDOM_ARBITER_data_OutBUS,
    output logic                 SC_PSRANDOM_ARBITER_valid_Out,
    output logic                 SC_PSRANDOM_ARBITER_busy_Out
);
    typedef enum logic [1:0] {IDLE, SHIFT, DELIVER} state_t;
    state_t               state;
    logic [DATAWIDTH-1:0] lfsr;
    logic [2:0]           cnt;
    logic [1:0]           last, winner, pick;
    logic                 any_req, fb;

    assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0];
    assign SC_PSRANDOM_ARBITER_data_OutBUS = lfsr;

    // Walk offsets 4 down to 1 so the requester nearest after last wins; last itself ranks lowest.
    always_comb begin
        pick    = last;
        any_req = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            if (SC_PSRANDOM_ARBITER_req_InBUS[last + 2'(i)]) begin
                pick    = last + 2'(i);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge SC_PSRANDOM_ARBITER_CLOCK_50) begin
        if (!SC_PSRANDOM_ARBITER_RESET_InLow) begin
            lfsr                           <= 8'h81;
            state                          <= IDLE;
            cnt                            <= 3'd0;
            last                           <= 2'd3;
            winner                         <= 2'd0;
            SC_PSRANDOM_ARBITER_gnt_OutBUS <= '0;
            SC_PSRANDOM_ARBITER_valid_Out  <= 1'b0;
            SC_PSRANDOM_ARBITER_busy_Out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (SC_PSRANDOM_ARBITER_seedLoad_In) begin
                        // An all-zero seed would freeze the LFSR, so substitute the reset value.
                        lfsr <= (SC_PSRANDOM_ARBITER_seed_InBUS == '0) ? 8'h81 : SC_PSRANDOM_ARBITER_seed_InBUS;
                    end else if (any_req) begin
                        winner                       <= pick;
                        cnt                          <= 3'd0;
                        state                        <= SHIFT;
                        SC_PSRANDOM_ARBITER_busy_Out <= 1'b1;
                    end
                end
                SHIFT: begin
                    lfsr <= {lfsr[6:0], fb};
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state                          <= DELIVER;
                        SC_PSRANDOM_ARBITER_valid_Out  <= 1'b1;
                        SC_PSRANDOM_ARBITER_gnt_OutBUS <= NREQ'(1) << winner;
                    end
                end
                DELIVER: begin
                    last                           <= winner;
                    state                          <= IDLE;
                    SC_PSRANDOM_ARBITER_valid_Out  <= 1'b0;
                    SC_PSRANDOM_ARBITER_gnt_OutBUS <= '0;
                    SC_PSRANDOM_ARBITER_busy_Out   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_psrandom_arbiter.sv
// tb_sc_psrandom_arbiter: scoreboard bench for the round-robin LFSR arbiter
module tb_sc_psrandom_arbiter;
    logic       clk = 1'b0;
    logic       rst_n, seed_load, valid, busy;
    logic [3:0] req, gnt;
    logic [7:0] seed, data;
    int         tests = 0, fails = 0;
    int         cyc, busy_n, stray;
    int         ev_cyc[$];
    logic [3:0] ev_gnt[$];
    logic [7:0] ev_dat[$];
    typedef struct { int cyc; logic [3:0] gnt; logic [7:0] dat; } exp_t;
    exp_t       sb[$];

    always #5 clk = ~clk;

    sc_psrandom_arbiter dut (
        .SC_PSRANDOM_ARBITER_CLOCK_50   (clk),
        .SC_PSRANDOM_ARBITER_RESET_InLow(rst_n),
        .SC_PSRANDOM_ARBITER_req_InBUS  (req),
        .SC_PSRANDOM_ARBITER_seed_InBUS (seed),
        .SC_PSRANDOM_ARBITER_seedLoad_In(seed_load),
        .SC_PSRANDOM_ARBITER_gnt_OutBUS (gnt),
        .SC_PSRANDOM_ARBITER_data_OutBUS(data),
        .SC_PSRANDOM_ARBITER_valid_Out  (valid),
        .SC_PSRANDOM_ARBITER_busy_Out   (busy)
    );

    function automatic logic [7:0] step8(input logic [7:0] x);
        logic [7:0] v;
        v = x;
        for (int i = 0; i < 8; i++) v = {v[6:0], v[7] ^ v[5] ^ v[3] ^ v[0]};
        return v;
    endfunction

    // Advance n cycles, sampling 1 ns after each edge and recording every delivered word.
    task automatic watch(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_n++;
            if ((gnt != 4'b0) != valid) stray++;
            if (valid) begin
                ev_cyc.push_back(cyc);
                ev_gnt.push_back(gnt);
                ev_dat.push_back(data);
            end
        end
    endtask

    task automatic start();
        rst_n = 1'b0; req = 4'b0; seed = 8'h00; seed_load = 1'b0;
        watch(1);
        rst_n = 1'b1;
        cyc = 0; busy_n = 0; stray = 0;
        ev_cyc.delete(); ev_gnt.delete(); ev_dat.delete(); sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b1111; seed = 8'h55; seed_load = 1'b1;
        watch(1);
        tests++; if (gnt !== 4'b0)  begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (data !== 8'h81) begin fails++; $display("FAIL reset_data: got %h want 81", data); end
        rst_n = 1'b1; req = 4'b0; seed_load = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        start();
        req = 4'b0001; sb.push_back('{cyc + 9, 4'b0001, 8'h18});
        watch(1); req = 4'b0;
        watch(11);
        tests++; if (ev_cyc.size() != 1) begin fails++; $display("FAIL single_count: got %0d grants want 1", ev_cyc.size()); end
        while (sb.size() > 0 && ev_cyc.size() > 0) begin
            e = sb.pop_front(); tests++;
            if (ev_cyc[0] !== e.cyc || ev_gnt[0] !== e.gnt || ev_dat[0] !== e.dat) begin
                fails++; $display("FAIL single_word: got cyc %0d gnt %b data %h want cyc %0d gnt %b data %h", ev_cyc[0], ev_gnt[0], ev_dat[0], e.cyc, e.gnt, e.dat);
            end
            void'(ev_cyc.pop_front()); void'(ev_gnt.pop_front()); void'(ev_dat.pop_front());
        end
        tests++; if (busy_n != 9) begin fails++; $display("FAIL single_busy: got %0d busy cycles want 9", busy_n); end
        tests++; if (stray != 0) begin fails++; $display("FAIL single_stray: got %0d stray grant cycles want 0", stray); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic [7:0] m;
        start();
        req = 4'b1111; m = 8'h81;
        for (int k = 0; k < 5; k++) begin
            m = step8(m);
            sb.push_back('{9 + 10 * k, 4'b0001 << (k % 4), m});
        end
        watch(50); req = 4'b0;
        watch(10);
        tests++; if (ev_cyc.size() != 5) begin fails++; $display("FAIL rr_count: got %0d grants want 5", ev_cyc.size()); end
        while (sb.size() > 0 && ev_cyc.size() > 0) begin
            e = sb.pop_front(); tests++;
            if (ev_cyc[0] !== e.cyc || ev_gnt[0] !== e.gnt || ev_dat[0] !== e.dat) begin
                fails++; $display("FAIL rr_word: got cyc %0d gnt %b data %h want cyc %0d gnt %b data %h", ev_cyc[0], ev_gnt[0], ev_dat[0], e.cyc, e.gnt, e.dat);
            end
            void'(ev_cyc.pop_front()); void'(ev_gnt.pop_front()); void'(ev_dat.pop_front());
        end
        tests++; if (busy_n != 45) begin fails++; $display("FAIL rr_busy: got %0d busy cycles want 45", busy_n); end
        tests++; if (stray != 0) begin fails++; $display("FAIL rr_stray: got %0d stray grant cycles want 0", stray); end
    endtask

    task automatic test_seed();
        exp_t e;
        start();
        req = 4'b0001; sb.push_back('{cyc + 9, 4'b0001, 8'h18});
        watch(1); req = 4'b0;
        watch(10);
        seed = 8'h00; seed_load = 1'b1;
        watch(1); seed_load = 1'b0;
        tests++; if (data !== 8'h81) begin fails++; $display("FAIL seed_zero_load: got %h want 81", data); end
        req = 4'b0001; sb.push_back('{cyc + 9, 4'b0001, 8'h18});
        watch(1); req = 4'b0;
        watch(10);
        seed = 8'h01; seed_load = 1'b1;
        watch(1); seed_load = 1'b0;
        tests++; if (data !== 8'h01) begin fails++; $display("FAIL seed_one_load: got %h want 01", data); end
        req = 4'b0001; sb.push_back('{cyc + 9, 4'b0001, 8'hEF});
        watch(1); req = 4'b0;
        watch(10);
        tests++; if (ev_cyc.size() != 3) begin fails++; $display("FAIL seed_count: got %0d grants want 3", ev_cyc.size()); end
        while (sb.size() > 0 && ev_cyc.size() > 0) begin
            e = sb.pop_front(); tests++;
            if (ev_cyc[0] !== e.cyc || ev_gnt[0] !== e.gnt || ev_dat[0] !== e.dat) begin
                fails++; $display("FAIL seed_word: got cyc %0d gnt %b data %h want cyc %0d gnt %b data %h", ev_cyc[0], ev_gnt[0], ev_dat[0], e.cyc, e.gnt, e.dat);
            end
            void'(ev_cyc.pop_front()); void'(ev_gnt.pop_front()); void'(ev_dat.pop_front());
        end
    endtask

    task automatic test_seed_priority();
        exp_t e;
        start();
        seed = 8'h5A; seed_load = 1'b1; req = 4'b0100;
        sb.push_back('{cyc + 10, 4'b0100, step8(8'h5A)});
        watch(1); seed_load = 1'b0;
        watch(1); req = 4'b0;
        watch(12);
        tests++; if (ev_cyc.size() != 1) begin fails++; $display("FAIL prio_count: got %0d grants want 1", ev_cyc.size()); end
        while (sb.size() > 0 && ev_cyc.size() > 0) begin
            e = sb.pop_front(); tests++;
            if (ev_cyc[0] !== e.cyc || ev_gnt[0] !== e.gnt || ev_dat[0] !== e.dat) begin
                fails++; $display("FAIL prio_word: got cyc %0d gnt %b data %h want cyc %0d gnt %b data %h", ev_cyc[0], ev_gnt[0], ev_dat[0], e.cyc, e.gnt, e.dat);
            end
            void'(ev_cyc.pop_front()); void'(ev_gnt.pop_front()); void'(ev_dat.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        start();
        req = 4'b0001;
        watch(1); req = 4'b0;
        watch(3);
        rst_n = 1'b0;
        watch(1);
        tests++; if (data !== 8'h81) begin fails++; $display("FAIL midrst_data: got %h want 81", data); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        watch(10);
        req = 4'b0001; sb.push_back('{cyc + 9, 4'b0001, 8'h18});
        watch(1); req = 4'b0;
        watch(11);
        tests++; if (ev_cyc.size() != 1) begin fails++; $display("FAIL midrst_count: got %0d grants want 1", ev_cyc.size()); end
        while (sb.size() > 0 && ev_cyc.size() > 0) begin
            e = sb.pop_front(); tests++;
            if (ev_cyc[0] !== e.cyc || ev_gnt[0] !== e.gnt || ev_dat[0] !== e.dat) begin
                fails++; $display("FAIL midrst_word: got cyc %0d gnt %b data %h want cyc %0d gnt %b data %h", ev_cyc[0], ev_gnt[0], ev_dat[0], e.cyc, e.gnt, e.dat);
            end
            void'(ev_cyc.pop_front()); void'(ev_gnt.pop_front()); void'(ev_dat.pop_front());
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL midrst_stray: got %0d stray grant cycles want 0", stray); end
    endtask

    task automatic test_drop_and_seed();
        exp_t e;
        start();
        req = 4'b0010; sb.push_back('{cyc + 9, 4'b0010, 8'h18});
        watch(1); req = 4'b0;
        watch(2);
        seed = 8'h33; seed_load = 1'b1;
        watch(1); seed_load = 1'b0;
        watch(8);
        tests++; if (ev_cyc.size() != 1) begin fails++; $display("FAIL drop_count: got %0d grants want 1", ev_cyc.size()); end
        while (sb.size() > 0 && ev_cyc.size() > 0) begin
            e = sb.pop_front(); tests++;
            if (ev_cyc[0] !== e.cyc || ev_gnt[0] !== e.gnt || ev_dat[0] !== e.dat) begin
                fails++; $display("FAIL drop_word: got cyc %0d gnt %b data %h want cyc %0d gnt %b data %h", ev_cyc[0], ev_gnt[0], ev_dat[0], e.cyc, e.gnt, e.dat);
            end
            void'(ev_cyc.pop_front()); void'(ev_gnt.pop_front()); void'(ev_dat.pop_front());
        end
        tests++; if (data !== 8'h18) begin fails++; $display("FAIL drop_noseed: got %h want 18", data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_seed();
        test_seed_priority();
        test_reset_mid();
        test_drop_and_seed();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sc_psrandom_arbiter.md
SC_PSRANDOM_ARBITER -- requirements
Module: SC_PSRANDOM_ARBITER

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters; the value is fixed at 4.
REQ-002 SHALL have parameter DATAWIDTH, default 8, meaning the random word width; the value is fixed at 8 by the polynomial.
REQ-003 SHALL have port SC_PSRANDOM_ARBITER_CLOCK_50, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port SC_PSRANDOM_ARBITER_RESET_InLow, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port SC_PSRANDOM_ARBITER_req_InBUS, input, 4 bits: level request, one bit per requester.
REQ-006 SHALL have port SC_PSRANDOM_ARBITER_seed_InBUS, input, 8 bits: seed value.
REQ-007 SHALL have port SC_PSRANDOM_ARBITER_seedLoad_In, input, 1 bit: one-cycle seed load strobe.
REQ-008 SHALL have port SC_PSRANDOM_ARBITER_gnt_OutBUS, output, 4 bits: one-hot grant, high only in the DELIVER cycle.
REQ-009 SHALL have port SC_PSRANDOM_ARBITER_data_OutBUS, output, 8 bits: current LFSR register contents.
REQ-010 SHALL have port SC_PSRANDOM_ARBITER_valid_Out, output, 1 bit: data_OutBUS is a delivered word; high only in DELIVER.
REQ-011 SHALL have port SC_PSRANDOM_ARBITER_busy_Out, output, 1 bit: high in SHIFT and DELIVER.

Function
REQ-012 SHALL contain an 8-bit LFSR. Each step: next = {lfsr[6:0], fb}, where fb = lfsr[7]^lfsr[5]^lfsr[3]^lfsr[0].
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DELIVER; the LFSR steps only in SHIFT cycles.
REQ-014 IDLE with seedLoad_In=1 SHALL load the seed into the LFSR and stay in IDLE.
REQ-015 A seed value of 0x00 SHALL load 0x81 instead, so the LFSR never locks up.
REQ-016 seedLoad_In SHALL have priority over requests in the same IDLE cycle; that request is serviced in the next IDLE cycle.
REQ-017 IDLE with no seed load and any req bit set SHALL pick a winner round-robin, searching from (last+1) mod 4 upward with wrap-around.
REQ-018 On that choice the FSM SHALL latch the winner, clear the shift counter and go to SHIFT.
REQ-019 SHIFT SHALL step the LFSR and increment a 3-bit counter every cycle; the cycle with counter==7 SHALL go to DELIVER, giving exactly 8 steps.
REQ-020 DELIVER SHALL last one cycle and drive:
- valid_Out=1;
- gnt_OutBUS one-hot for the latched winner;
- data_OutBUS = the LFSR contents.
REQ-021 At the end of DELIVER the FSM SHALL set last=winner and return to IDLE.
REQ-022 Latency SHALL be: request accepted in IDLE cycle T, then gnt/valid in cycle T+9; peak throughput is one word per 10 cycles.
REQ-023 seedLoad_In and req_InBUS changes during SHIFT/DELIVER SHALL be ignored; a transaction in progress always completes and its grant pulses even if the winner drops req.
REQ-024 A requester that holds req SHALL receive at most one grant per arbitration round, so no requester starves when all four request.
REQ-025 gnt_OutBUS SHALL be 0 and valid_Out SHALL be 0 in every state except DELIVER.

Reset
REQ-026 With RESET_InLow=0 at a rising edge, the block SHALL set: LFSR=0x81, state=IDLE, counter=0, last=3 (requester 0 has first priority).
REQ-027 Reset SHALL give gnt_OutBUS=0, valid_Out=0, busy_Out=0 and data_OutBUS=0x81.
REQ-028 Reset during SHIFT or DELIVER SHALL abort the transaction with no grant issued; reset SHALL override seedLoad_In.

Verification
REQ-029 Reset release, then req=0001 held one cycle -> busy for 9 cycles, and in cycle T+9: gnt=0001, valid=1, data=0x18.
REQ-030 Reset release, then req=1111 held -> grants in order 0001, 0010, 0100, 1000 with data 0x18, 0xA0, ..., each 10 cycles apart, then wrap to 0001.
REQ-031 seed=0x00 with seedLoad=1 in IDLE, then req=0001 -> data=0x18 (0x81 substituted); seed=0x01 loaded, then req -> data=0xEF.
REQ-032 seedLoad=1 and req=0100 in the same IDLE cycle -> seed loaded; grant 0100 arrives 10 cycles later (T+10) with the word derived from the seed.
REQ-033 RESET_InLow=0 for one cycle mid-SHIFT -> no gnt/valid pulse, data=0x81; a following req=0001 yields data=0x18.
REQ-034 req=0010 dropped after acceptance, with seedLoad pulsed during SHIFT -> gnt=0010 still pulses at T+9 and the seed is not loaded.
